// File: rtl/clk_phase_pkg.sv
// Shared types and helpers for the parametrised bus-clock phase generator.
// Default parameter values, per-phase offset/fast-divider helpers and the clock bundle type.
package clk_phase_pkg;

    localparam int DEF_DIV      = 8;
    localparam int DEF_NUM_PH   = 4;
    localparam int DEF_FAST_MUL = 2;

    localparam int PH_OFS = DEF_DIV / DEF_NUM_PH;
    localparam int F      = DEF_DIV / DEF_FAST_MUL;

    // Field order matches the legacy [2:0] {fall, rise, lvl} packing.
    typedef struct packed {
        logic fall;
        logic rise;
        logic lvl;
    } clk_bundle_t;

    // High for the first half of a period of length 'period', delayed by 'ofs' ticks.
    function automatic logic wave_lvl(input int c, input int ofs, input int period);
        int d;
        d = (c - ofs) % period;
        if (d < 0) d = d + period;
        return (d < period / 2);
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Registered level with one-cycle rise/fall strobes, updated only on ticks.
module clk_edge_det
    import clk_phase_pkg::*;
#(
    parameter logic RST_LVL = 1'b0
) (
    input  logic        main_clk,
    input  logic        main_rst,
    input  logic        tick,
    input  logic        nxt_lvl,
    output clk_bundle_t bundle
);

    always_ff @(posedge main_clk or negedge main_rst) begin
        if (!main_rst) begin
            bundle.lvl  <= RST_LVL;
            bundle.rise <= 1'b0;
            bundle.fall <= 1'b0;
        end else begin
            bundle.lvl  <= tick ? nxt_lvl : bundle.lvl;
            bundle.rise <= tick & nxt_lvl & ~bundle.lvl;
            bundle.fall <= tick & ~nxt_lvl & bundle.lvl;
        end
    end

endmodule

// File: rtl/clk_phase_gen.sv
// NUM_PH slow bus-clock phases plus a quadrature fast pair derived from a tick enable.
// Optional wait-state stretching is enabled with the CLK_PH_STRETCH_EN macro.
module clk_phase_gen
    import clk_phase_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int NUM_PH   = DEF_NUM_PH,
    parameter int FAST_MUL = DEF_FAST_MUL,
    parameter int CW       = 3
) (
    input  logic              main_clk,
    input  logic              main_rst,
    input  logic              ena_in,
    input  logic              resync_in,
`ifdef CLK_PH_STRETCH_EN
    input  logic              stretch_in,
`endif
    output logic [NUM_PH-1:0] ph_lvl,
    output logic [NUM_PH-1:0] ph_rise,
    output logic [NUM_PH-1:0] ph_fall,
    output logic [1:0]        fst_lvl,
    output logic [1:0]        fst_rise,
    output logic [1:0]        fst_fall,
    output logic [CW-1:0]     cnt_out
);

    localparam int PH_STEP = DIV / NUM_PH;
    localparam int FST_DIV = DIV / FAST_MUL;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0]     cnt_p0;
    logic [CW-1:0]     cnt_nxt;
    logic              pend_p0;
    logic              hold;
    logic [NUM_PH-1:0] ph_nxt;
    logic [1:0]        fst_nxt;

    always_comb begin
        hold = 1'b0;
`ifdef CLK_PH_STRETCH_EN
        hold = stretch_in && (cnt_p0 == LAST);
`endif
        cnt_nxt = cnt_p0;
        if (ena_in) begin
            if (resync_in || pend_p0)
                cnt_nxt = '0;
            else if (hold)
                cnt_nxt = cnt_p0;
            else if (cnt_p0 == LAST)
                cnt_nxt = '0;
            else
                cnt_nxt = cnt_p0 + CW'(1);
        end
    end

    // Stage p0: tick counter and pending realign request.
    always_ff @(posedge main_clk or negedge main_rst) begin
        if (!main_rst) begin
            cnt_p0  <= '0;
            pend_p0 <= 1'b0;
        end else begin
            cnt_p0 <= cnt_nxt;
            if (ena_in)
                pend_p0 <= 1'b0;
            else if (resync_in)
                pend_p0 <= 1'b1;
        end
    end

    always_comb begin
        ph_nxt = '0;
        for (int k = 0; k < NUM_PH; k++)
            ph_nxt[k] = wave_lvl(int'(cnt_nxt), k * PH_STEP, DIV);
        fst_nxt[0] = wave_lvl(int'(cnt_nxt), 0, FST_DIV);
        fst_nxt[1] = wave_lvl(int'(cnt_nxt), FST_DIV / 4, FST_DIV);
    end

    // Levels are evaluated on the next count so they move on the same edge as cnt_out.
    genvar k;
    generate
        for (k = 0; k < NUM_PH; k++) begin : g_ph
            clk_bundle_t b;
            clk_edge_det #(.RST_LVL(wave_lvl(0, k * PH_STEP, DIV))) u_det (
                .main_clk (main_clk),
                .main_rst (main_rst),
                .tick     (ena_in),
                .nxt_lvl  (ph_nxt[k]),
                .bundle   (b)
            );
            assign ph_lvl[k]  = b.lvl;
            assign ph_rise[k] = b.rise;
            assign ph_fall[k] = b.fall;
        end
        for (k = 0; k < 2; k++) begin : g_fst
            clk_bundle_t b;
            clk_edge_det #(.RST_LVL(wave_lvl(0, k * (FST_DIV / 4), FST_DIV))) u_det (
                .main_clk (main_clk),
                .main_rst (main_rst),
                .tick     (ena_in),
                .nxt_lvl  (fst_nxt[k]),
                .bundle   (b)
            );
            assign fst_lvl[k]  = b.lvl;
            assign fst_rise[k] = b.rise;
            assign fst_fall[k] = b.fall;
        end
    endgenerate

    assign cnt_out = cnt_p0;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Randomised and directed bench for clk_phase_gen, default and NUM_PH=2/DIV=16 instances.
module tb_clk_phase_gen;

    logic main_clk = 1'b0;
    logic main_rst = 1'b1;
    logic ena_in = 1'b0;
    logic resync_in = 1'b0;
`ifdef CLK_PH_STRETCH_EN
    logic stretch_in = 1'b0;
    localparam bit HAS_STRETCH = 1'b1;
`else
    localparam bit HAS_STRETCH = 1'b0;
`endif

    always #5 main_clk = ~main_clk;

    logic [3:0] a_ph_lvl, a_ph_rise, a_ph_fall;
    logic [1:0] a_fst_lvl, a_fst_rise, a_fst_fall;
    logic [2:0] a_cnt;
    logic [1:0] b_ph_lvl, b_ph_rise, b_ph_fall;
    logic [1:0] b_fst_lvl, b_fst_rise, b_fst_fall;
    logic [3:0] b_cnt;

    clk_phase_gen #(.DIV(8), .NUM_PH(4), .FAST_MUL(2), .CW(3)) dut_a (
        .main_clk(main_clk), .main_rst(main_rst), .ena_in(ena_in), .resync_in(resync_in),
`ifdef CLK_PH_STRETCH_EN
        .stretch_in(stretch_in),
`endif
        .ph_lvl(a_ph_lvl), .ph_rise(a_ph_rise), .ph_fall(a_ph_fall),
        .fst_lvl(a_fst_lvl), .fst_rise(a_fst_rise), .fst_fall(a_fst_fall),
        .cnt_out(a_cnt)
    );

    clk_phase_gen #(.DIV(16), .NUM_PH(2), .FAST_MUL(4), .CW(4)) dut_b (
        .main_clk(main_clk), .main_rst(main_rst), .ena_in(ena_in), .resync_in(resync_in),
`ifdef CLK_PH_STRETCH_EN
        .stretch_in(stretch_in),
`endif
        .ph_lvl(b_ph_lvl), .ph_rise(b_ph_rise), .ph_fall(b_ph_fall),
        .fst_lvl(b_fst_lvl), .fst_rise(b_fst_rise), .fst_fall(b_fst_fall),
        .cnt_out(b_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    int P_DIV [2] = '{8, 16};
    int P_NPH [2] = '{4, 2};
    int P_FM  [2] = '{2, 4};

    int       m_cnt [2];
    bit       m_pend[2];
    bit [3:0] m_ph  [2];
    bit [3:0] m_phr [2];
    bit [3:0] m_phf [2];
    bit [1:0] m_fl  [2];
    bit [1:0] m_fr  [2];
    bit [1:0] m_ff  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position within a period, shifted by ofs; high for the first half.
    function automatic bit wl(input int c, input int ofs, input int period);
        return ((c + 4 * period - ofs) % period) < (period / 2);
    endfunction

    task automatic levels(input int i, output bit [3:0] ph, output bit [1:0] fl);
        int f;
        f  = P_DIV[i] / P_FM[i];
        ph = '0;
        for (int k = 0; k < P_NPH[i]; k++)
            ph[k] = wl(m_cnt[i], k * P_DIV[i] / P_NPH[i], P_DIV[i]);
        fl[0] = wl(m_cnt[i], 0, f);
        fl[1] = wl(m_cnt[i], f / 4, f);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pend[i] = 0;
            levels(i, m_ph[i], m_fl[i]);
            m_phr[i] = '0; m_phf[i] = '0; m_fr[i] = '0; m_ff[i] = '0;
        end
    endtask

    task automatic model_step(input bit e, input bit r, input bit s);
        bit [3:0] oph, nph;
        bit [1:0] ofl, nfl;
        if (!main_rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            oph = m_ph[i]; ofl = m_fl[i];
            if (e) begin
                if (r || m_pend[i]) m_cnt[i] = 0;
                else if (!(HAS_STRETCH && s && m_cnt[i] == P_DIV[i] - 1))
                    m_cnt[i] = (m_cnt[i] + 1) % P_DIV[i];
                m_pend[i] = 0;
            end else if (r) begin
                m_pend[i] = 1;
            end
            levels(i, nph, nfl);
            m_ph[i] = nph; m_fl[i] = nfl;
            m_phr[i] = e ? (nph & ~oph) : 4'b0;
            m_phf[i] = e ? (~nph & oph) : 4'b0;
            m_fr[i]  = e ? (nfl & ~ofl) : 2'b0;
            m_ff[i]  = e ? (~nfl & ofl) : 2'b0;
        end
    endtask

    task automatic compare_all();
        chk("a_cnt", 32'(a_cnt), 32'(m_cnt[0]));
        chk("a_ph_lvl", 32'(a_ph_lvl), 32'(m_ph[0]));
        chk("a_ph_rise", 32'(a_ph_rise), 32'(m_phr[0]));
        chk("a_ph_fall", 32'(a_ph_fall), 32'(m_phf[0]));
        chk("a_fst_lvl", 32'(a_fst_lvl), 32'(m_fl[0]));
        chk("a_fst_rise", 32'(a_fst_rise), 32'(m_fr[0]));
        chk("a_fst_fall", 32'(a_fst_fall), 32'(m_ff[0]));
        chk("b_cnt", 32'(b_cnt), 32'(m_cnt[1]));
        chk("b_ph_lvl", 32'(b_ph_lvl), 32'(m_ph[1]));
        chk("b_ph_rise", 32'(b_ph_rise), 32'(m_phr[1]));
        chk("b_ph_fall", 32'(b_ph_fall), 32'(m_phf[1]));
        chk("b_fst_lvl", 32'(b_fst_lvl), 32'(m_fl[1]));
        chk("b_fst_rise", 32'(b_fst_rise), 32'(m_fr[1]));
        chk("b_fst_fall", 32'(b_fst_fall), 32'(m_ff[1]));
    endtask

    task automatic cyc(input bit e, input bit r, input bit s);
        ena_in = e;
        resync_in = r;
`ifdef CLK_PH_STRETCH_EN
        stretch_in = s;
`endif
        @(posedge main_clk);
        @(negedge main_clk);
        model_step(e, r, s);
        compare_all();
    endtask

    bit [3:0] seq [8] = '{4'b1001, 4'b0011, 4'b0011, 4'b0110,
                          4'b0110, 4'b1100, 4'b1100, 4'b1001};

    initial begin
        int last;
        int mode;
        bit e, r, s;

        #2 main_rst = 1'b0;
        @(negedge main_clk);
        model_reset();
        compare_all();
        chk("rst_a_ph", 32'(a_ph_lvl), 32'h9);
        chk("rst_a_fst", 32'(a_fst_lvl), 32'h1);
        chk("rst_a_cnt", 32'(a_cnt), 32'h0);
        chk("rst_b_ph", 32'(b_ph_lvl), 32'h1);
        chk("rst_b_fst", 32'(b_fst_lvl), 32'h1);
        main_rst = 1'b1;

        // ena every 4th cycle: literal phase sequence.
        for (int t = 1; t <= 8; t++) begin
            cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
            cyc(1, 0, 0);
            chk("seq_ph_lvl", 32'(a_ph_lvl), 32'(seq[t-1]));
            chk("seq_cnt", 32'(a_cnt), 32'(t % 8));
        end
        chk("seq_ph_rise0", 32'(a_ph_rise[0]), 32'h1);

        // ena constant: fast rise spacing.
        last = -1;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0);
            if (a_fst_rise[0] === 1'b1) begin
                if (last >= 0) chk("fst_rise_gap", 32'(i - last), 32'd4);
                last = i;
            end
        end

        // Pending resync at cnt=5.
        for (int i = 0; i < 16 && m_cnt[0] != 5; i++) cyc(1, 0, 0);
        chk("pre_resync_cnt", 32'(a_cnt), 32'd5);
        cyc(0, 1, 0);
        chk("resync_wait_cnt", 32'(a_cnt), 32'd5);
        cyc(0, 0, 0);
        chk("resync_hold_cnt", 32'(a_cnt), 32'd5);
        cyc(1, 0, 0);
        chk("resync_cnt", 32'(a_cnt), 32'd0);
        chk("resync_rise0", 32'(a_ph_rise[0]), 32'h1);
        chk("resync_ph", 32'(a_ph_lvl), 32'h9);

        // Async reset mid-cycle at cnt=6, with a resync pending that must be lost.
        for (int i = 0; i < 16 && m_cnt[0] != 6; i++) cyc(1, 0, 0);
        cyc(0, 1, 0);
        #2 main_rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_cnt", 32'(a_cnt), 32'd0);
        chk("arst_ph", 32'(a_ph_lvl), 32'h9);
        chk("arst_strobes", 32'({a_ph_rise, a_ph_fall, a_fst_rise, a_fst_fall}), 32'h0);
        @(negedge main_clk);
        main_rst = 1'b1;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("post_rst_cnt", 32'(a_cnt), 32'd1);

`ifdef CLK_PH_STRETCH_EN
        for (int i = 0; i < 16 && m_cnt[0] != 7; i++) cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1);
            chk("stretch_cnt", 32'(a_cnt), 32'd7);
            chk("stretch_strobes", 32'({a_ph_rise, a_ph_fall, a_fst_rise, a_fst_fall}), 32'h0);
        end
        cyc(1, 0, 0);
        chk("stretch_rel_cnt", 32'(a_cnt), 32'd0);
        chk("stretch_rel_rise0", 32'(a_ph_rise[0]), 32'h1);
`endif

        // Randomised traffic in three enable modes, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 256) % 3;
            case (mode)
                0:       e = bit'($urandom_range(0, 1));
                1:       e = 1'b1;
                default: e = ($urandom_range(0, 3) == 0);
            endcase
            r = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 2) == 0);
            main_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cyc(e, r, s);
        end
        main_rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_phase_gen.md
Name: clk_phase_gen

Overview:
- Parametrised successor of the fixed Amiga clock generator: derives NUM_PH evenly spaced slow bus-clock phases plus one fast clock pair from a single master-clock enable.
- Slow phases correspond to C1..C4 / CCK / CCKQ; the fast pair corresponds to C7M / CDAC.
- Every output is a level plus one-cycle rise and fall strobes in the main_clk domain. Downstream chip models (Agnus, Alice, Denise, Paula) consume the strobes as clock enables.
- Adds resynchronisation and optional wait-state stretching.

Parameters:
- DIV, 8: ena_in pulses per slow cycle; must be even, divisible by NUM_PH and by 4*FAST_MUL.
- NUM_PH, 4: number of slow phases; phase k lags phase 0 by k*DIV/NUM_PH ticks.
- FAST_MUL, 2: fast clock frequency = FAST_MUL x slow frequency.
- CW, 3: counter width, must satisfy 2^CW >= DIV.

Ports:
- main_clk  in  1  master clock; all logic rising-edge.
- main_rst  in  1  asynchronous, active-low reset.
- ena_in  in  1  tick enable (the 28 MHz oscillator enable); the counter advances only on ticks.
- resync_in  in  1  realign request; forces the counter to 0 at the next tick.
- ph_lvl  out  NUM_PH  slow phase levels.
- ph_rise  out  NUM_PH  one-cycle strobe, first cycle a level is high.
- ph_fall  out  NUM_PH  one-cycle strobe, first cycle a level is low.
- fst_lvl  out  2  fast levels: [0] in-phase (C7M), [1] lagging 90 degrees (CDAC).
- fst_rise  out  2  fast rise strobes.
- fst_fall  out  2  fast fall strobes.
- cnt_out  out  CW  current tick counter 0..DIV-1.

Behaviour:
- Counter cnt: on main_clk edge with ena_in=1, cnt <= (cnt==DIV-1) ? 0 : cnt+1. Without ena_in, cnt holds.
- Phase level, registered: ph_lvl[k] = ((cnt - k*DIV/NUM_PH) mod DIV) < DIV/2. Evaluated on the next cnt, so levels change on the same edge as cnt.
- Fast level: with F = DIV/FAST_MUL:
  - fst_lvl[0] = (cnt mod F) < F/2.
  - fst_lvl[1] = ((cnt - F/4) mod F) < F/2.
- Strobes, registered:
  - x_rise = 1 for exactly one main_clk cycle, the cycle in which the new level first reads 1 after reading 0.
  - x_fall likewise for the 1-to-0 transition.
  - Strobes are never asserted for two consecutive cycles.
  - Strobes fire only on edges where ena_in=1.
- Latency: a tick edge updates cnt_out, levels and strobes together; there is no extra pipeline stage.
- Reset (main_rst=0, async):
  - cnt=0, levels at their cnt=0 values; for the defaults ph_lvl=4'b1001, fst_lvl=2'b01.
  - All strobes 0, pending-resync flag cleared.
  - Release is synchronous to main_clk. The first tick after release yields cnt=1.
- Resync:
  - resync_in=1 with ena_in=1: cnt <= 0.
  - resync_in=1 without ena_in: set pending flag; the next tick forces cnt <= 0 and clears the flag.
  - Resync while cnt==DIV-1 is indistinguishable from a normal wrap.
  - Levels and strobes follow the recomputed values, so shortened phases and their edges are legal.
- Reset mid-cycle: outputs return to reset values immediately; any pending resync is lost.
- ena_in held permanently high is legal: the slow cycle is DIV main_clk cycles.

Optional Feature:
- Macro CLK_PH_STRETCH_EN.
- Defined:
  - Adds input stretch_in (1 bit).
  - On a tick where cnt==DIV-1 and stretch_in=1, cnt holds at DIV-1, levels hold and no strobes fire. This implements wait states; the slow clocks freeze in the last quarter.
  - resync_in overrides stretch_in.
- Undefined: the port is absent and the counter never holds on a tick.

Decomposition:
- Package clk_phase_pkg holds:
  - Localparam helpers: PH_OFS = DIV/NUM_PH, F = DIV/FAST_MUL.
  - A typedef for the 3-bit {fall, rise, lvl} clock bundle, so integrators can repack into the legacy [2:0] format.
- One natural sub-module, clk_edge_det: takes next-level and tick, and produces the registered lvl/rise/fall. It is instantiated NUM_PH+2 times.

Test Plan:
- Defaults, ena_in every 4th cycle (28 MHz from ~114 MHz): ph_lvl sequence per tick is 1001, 1001, 0011, 0011, 0110, 0110, 1100, 1100, repeating. ph_rise[0] fires once per 8 ticks, at the tick where cnt becomes 0.
- ena_in constant 1: fst_lvl[0] toggles every 2 cycles; fst_lvl[1] lags it by exactly 1 cycle. Each fst_rise[0] is one cycle wide, 4 cycles apart.
- resync_in pulsed without ena_in at cnt=5: no change until the next tick, then cnt_out=0, ph_rise[0]=1 and ph_lvl=1001.
- Async reset asserted mid-cycle at cnt=6: outputs go immediately to cnt_out=0, ph_lvl=1001, strobes 0. After release, the first tick gives cnt_out=1.
- With CLK_PH_STRETCH_EN, stretch_in=1 for 3 ticks at cnt=7: cnt_out stays 7 with no strobes. The release tick gives cnt=0 and ph_rise[0]=1.
- NUM_PH=2, DIV=16, FAST_MUL=4: ph_lvl[1] is phase 0 inverted. fst_lvl[0] period is 4 ticks.
